// File: rtl/alu_dispatch_pkg.sv
// Shared definitions for the ALU dispatcher and the ALU it drives:
// default widths, ALUop encodings and the dispatcher FSM states.
package alu_dispatch_pkg;

    localparam int ALU_DATA_WIDTH = 32;
    localparam int ALU_ADDR_WIDTH = 5;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    // Only the arithmetic ops can have their write-back squashed by overflow.
    function automatic logic op_can_overflow(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_dispatch_reg_file.sv
// Register file: two async operand read ports plus an async debug tap, one sync write port.
// Synchronous reset clears every entry; entry 0 always reads zero and ignores writes.
module reg_file
    import alu_dispatch_pkg::*;
#(
    parameter int DW = ALU_DATA_WIDTH,
    parameter int AW = ALU_ADDR_WIDTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] ra_addr,
    output logic [DW-1:0] ra_data,
    input  logic [AW-1:0] rb_addr,
    output logic [DW-1:0] rb_data,
    input  logic [AW-1:0] dbg_addr,
    output logic [DW-1:0] dbg_data,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd
);

    localparam int NREG = 1 << AW;

    logic [DW-1:0] regs_q [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs_q[wa] <= wd;
        end
    end

    assign ra_data  = (ra_addr  == '0) ? '0 : regs_q[ra_addr];
    assign rb_data  = (rb_addr  == '0) ? '0 : regs_q[rb_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : regs_q[dbg_addr];

endmodule

// File: rtl/alu_dispatch.sv
// Dispatches one register/immediate command to an external combinational ALU every 3 cycles:
// IDLE accepts and latches operands, EXEC captures result+flags, WB writes back and pulses done.
module alu_dispatch #(
    parameter int DATA_WIDTH = alu_dispatch_pkg::ALU_DATA_WIDTH,
    parameter int ADDR_WIDTH = alu_dispatch_pkg::ALU_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_rs,
    input  logic [ADDR_WIDTH-1:0] cmd_rt,
    input  logic [ADDR_WIDTH-1:0] cmd_rd,
    input  logic                  cmd_imm_en,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [2:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_overflow,
    input  logic                  alu_carryout,
    output logic                  done,
    output logic                  done_zero,
    output logic                  done_ovf,
    output logic                  done_carry,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);
    import alu_dispatch_pkg::*;

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, b_q, res_q;
    logic [DATA_WIDTH-1:0]   b_d;
    logic [2:0]              op_q;
    logic [ADDR_WIDTH-1:0]   rd_q;
    logic                    zero_q, ovf_q, carry_q;
    logic [DATA_WIDTH-1:0]   rs_data, rt_data;
    logic                    accept;
    logic                    in_wb;
    logic                    wb_en;

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign b_d       = cmd_imm_en ? cmd_imm : rt_data;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_EXEC;
            ST_EXEC: state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_AND;
            rd_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q  <= rs_data;
                b_q  <= b_d;
                op_q <= cmd_op;
                rd_q <= cmd_rd;
            end
            if (state_q == ST_EXEC) begin
                res_q   <= alu_result;
                zero_q  <= alu_zero;
                ovf_q   <= alu_overflow;
                carry_q <= alu_carryout;
            end
        end
    end

    // Gating with rst keeps a reset asserted in WB from leaking a done pulse or a write.
    assign in_wb = (state_q == ST_WB) && !rst;
    assign wb_en = in_wb && !(op_can_overflow(op_q) && ovf_q);

    assign alu_A      = a_q;
    assign alu_B      = b_q;
    assign alu_op     = op_q;
    assign done       = in_wb;
    assign done_zero  = in_wb && zero_q;
    assign done_ovf   = in_wb && ovf_q;
    assign done_carry = in_wb && carry_q;

    reg_file #(
        .DW (DATA_WIDTH),
        .AW (ADDR_WIDTH)
    ) u_reg_file (
        .clk      (clk),
        .rst      (rst),
        .ra_addr  (cmd_rs),
        .ra_data  (rs_data),
        .rb_addr  (cmd_rt),
        .rb_data  (rt_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (wb_en),
        .wa       (rd_q),
        .wd       (res_q)
    );

endmodule

// File: tb/tb_alu_dispatch.sv
// Randomized and directed bench for alu_dispatch with a behavioural ALU and register-file model.
module tb_alu_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
    logic        cmd_imm_en;
    logic [31:0] cmd_imm;
    logic [31:0] alu_A, alu_B;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero, alu_overflow, alu_carryout;
    logic        done, done_zero, done_ovf, done_carry;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mr [32];
    logic        obs_zero, obs_ovf, obs_carry;

    always #5 clk = ~clk;

    alu_dispatch dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
        .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .alu_overflow(alu_overflow), .alu_carryout(alu_carryout),
        .done(done), .done_zero(done_zero), .done_ovf(done_ovf), .done_carry(done_carry),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    // Behavioural ALU: returns {zero, overflow, carry, result}.
    function automatic logic [34:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        ov, cy;
        ov = 1'b0;
        cy = 1'b0;
        case (op)
            3'b000: r = a & b;
            3'b001: r = a | b;
            3'b010: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[31:0];
                cy = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b110: begin
                s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r  = s[31:0];
                cy = s[32];
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'b111: begin
                s  = {1'b0, a} + {1'b0, ~b} + 33'd1;
                cy = s[32];
                r  = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            end
            default: r = a ^ b;
        endcase
        return {(r == 32'd0), ov, cy, r};
    endfunction

    always_comb begin
        {alu_zero, alu_overflow, alu_carryout, alu_result} = alu_f(alu_A, alu_B, alu_op);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic read_dbg(input logic [4:0] a, input logic [31:0] exp, input string tag);
        dbg_addr = a;
        #1;
        check(tag, dbg_data, exp);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mr[i] = 32'd0;
        #1;
        check("rst_ready", cmd_ready, 1);
        check("rst_A", alu_A, 0);
        check("rst_B", alu_B, 0);
        check("rst_op", alu_op, 0);
        check("rst_done", {done, done_zero, done_ovf, done_carry}, 0);
    endtask

    // Issues one command from an IDLE negedge and returns at the negedge after WB.
    task automatic do_cmd(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs,
                          input logic [4:0] rt, input logic imm_en, input logic [31:0] imm);
        logic [31:0] ea, eb;
        logic [34:0] r;
        int w;
        w = 0;
        while (!cmd_ready && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("ready_before", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs; cmd_rt = rt;
        cmd_imm_en = imm_en; cmd_imm = imm;
        ea = mr[rs];
        eb = imm_en ? imm : mr[rt];
        r  = alu_f(ea, eb, op);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("exec_ready", cmd_ready, 0);
        check("exec_done", done, 0);
        check("exec_A", alu_A, ea);
        check("exec_B", alu_B, eb);
        check("exec_op", alu_op, op);
        @(negedge clk);
        obs_zero = done_zero; obs_ovf = done_ovf; obs_carry = done_carry;
        check("wb_done", done, 1);
        check("wb_flags", {done_zero, done_ovf, done_carry}, r[34:32]);
        if (!(((op == 3'b010) || (op == 3'b110)) && r[33]) && rd != 5'd0) mr[rd] = r[31:0];
        @(negedge clk);
        check("post_done", done, 0);
        check("post_ready", cmd_ready, 1);
        check("hold_A", alu_A, ea);
        read_dbg(rd, mr[rd], "wb_value");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] imm;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;
        cmd_imm_en = 1'b0; cmd_imm = '0; dbg_addr = '0;
        obs_zero = 1'b0; obs_ovf = 1'b0; obs_carry = 1'b0;
        do_reset();
        for (int i = 0; i < 32; i++) read_dbg(i[4:0], 32'd0, "rst_reg");

        do_cmd(3'b001, 5'd1, 5'd0, 5'd0, 1'b1, 32'h5);
        read_dbg(5'd1, 32'h5, "or_imm_r1");
        check("or_imm_zero", obs_zero, 0);

        do_cmd(3'b001, 5'd2, 5'd0, 5'd0, 1'b1, 32'h7);
        do_cmd(3'b110, 5'd3, 5'd1, 5'd2, 1'b0, 32'h0);
        read_dbg(5'd3, 32'hFFFF_FFFE, "sub_r3");
        check("sub_ovf", obs_ovf, 0);

        do_cmd(3'b001, 5'd1, 5'd0, 5'd0, 1'b1, 32'h7FFF_FFFF);
        do_cmd(3'b010, 5'd4, 5'd1, 5'd0, 1'b1, 32'h1);
        check("add_ovf", obs_ovf, 1);
        read_dbg(5'd4, 32'h0, "add_ovf_r4");

        do_cmd(3'b001, 5'd1, 5'd0, 5'd0, 1'b1, 32'h5);
        do_cmd(3'b111, 5'd5, 5'd2, 5'd1, 1'b0, 32'h0);
        read_dbg(5'd5, 32'h0, "slt_r5_0");
        check("slt_zero", obs_zero, 1);
        do_cmd(3'b111, 5'd5, 5'd1, 5'd2, 1'b0, 32'h0);
        read_dbg(5'd5, 32'h1, "slt_r5_1");

        do_cmd(3'b001, 5'd0, 5'd0, 5'd0, 1'b1, 32'hFFFF_FFFF);
        read_dbg(5'd0, 32'h0, "r0_zero");

        // Reset during EXEC: no done, nothing written, ready right after.
        cmd_valid = 1'b1; cmd_op = 3'b001; cmd_rd = 5'd6; cmd_rs = 5'd0; cmd_imm_en = 1'b1; cmd_imm = 32'h3;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) mr[i] = 32'd0;
        #1;
        check("rstexec_done", done, 0);
        check("rstexec_ready", cmd_ready, 1);
        read_dbg(5'd6, 32'h0, "rstexec_r6");
        read_dbg(5'd1, 32'h0, "rstexec_r1");

        // Reset during WB: done suppressed in that very cycle.
        cmd_valid = 1'b1; cmd_rd = 5'd6;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstwb_done", done, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        read_dbg(5'd6, 32'h0, "rstwb_r6");

        // Valid held high across EXEC/WB: next acceptance only 3 cycles later.
        cmd_valid = 1'b1; cmd_op = 3'b001; cmd_rd = 5'd7; cmd_rs = 5'd0; cmd_imm_en = 1'b1; cmd_imm = 32'd9;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); @(negedge clk);
            if (c == 1) cmd_imm = 32'd11;
            check("hold_ready", cmd_ready, (c % 3 == 0) ? 1 : 0);
            check("hold_done", done, (c % 3 == 2) ? 1 : 0);
        end
        cmd_valid = 1'b0;
        mr[7] = 32'd11;
        read_dbg(5'd7, 32'd11, "hold_r7");

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 4))
                0: imm = 32'h7FFF_FFFF;
                1: imm = 32'h8000_0000;
                2: imm = 32'hFFFF_FFFF;
                3: imm = 32'h1;
                default: imm = $urandom;
            endcase
            do_cmd($urandom_range(0, 7), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 1), imm);
            dbg_addr = $urandom_range(0, 31);
            read_dbg(dbg_addr, mr[dbg_addr], "rand_dbg");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
